// File: rtl/md_port_regs_if.sv
// CPU access bus for one MegaDrive port register block.
// Handshake: the CPU raises cpu_sel for one cycle; the block answers with cpu_ack one cycle later.
interface md_port_regs_if;
    logic       cpu_sel;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_ack;

    modport master (
        output cpu_sel, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack
    );

    modport slave (
        input  cpu_sel, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack
    );
endinterface

// File: rtl/md_port_regs.sv
// 68k-visible DATA/CTRL registers, pin drive/sample and TH interrupt for one controller port.
// Optional serial (TX on pin 4, RX on pin 5) is built when MD_PORT_SERIAL_EN is defined.
module md_port_regs #(
    parameter int         CLK_HZ   = 53693175,
    parameter logic [7:0] DATA_RST = 8'h7F
) (
    input  logic           clk,
    input  logic           reset,
    md_port_regs_if.slave  cpu,
    output logic [6:0]     port_in,
    output logic [6:0]     port_dir,
    input  logic [6:0]     port_out,
    output logic           th_int,
    output logic           ser_int
);

    logic [7:0] r_data;
    logic [7:0] r_ctrl;
    logic [7:0] r_dout;
    logic       r_ack;
    logic [6:0] r_smp;
    logic       r_th_d;
    logic       r_th_int;

    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_data_rd;
    logic [7:0] w_ser_rd;
    logic [7:0] w_rd_mux;

    assign w_wr = cpu.cpu_sel & cpu.cpu_we;
    assign w_rd = cpu.cpu_sel & ~cpu.cpu_we;

    // Output bits read back the latch, input bits read the sampled pin.
    assign w_data_rd = {r_data[7], (r_data[6:0] & r_ctrl[6:0]) | (r_smp & ~r_ctrl[6:0])};

    always_comb begin
        w_rd_mux = w_ser_rd;
        case (cpu.cpu_addr)
            3'd0:    w_rd_mux = w_data_rd;
            3'd1:    w_rd_mux = r_ctrl;
            default: w_rd_mux = w_ser_rd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= DATA_RST;
            r_ctrl   <= 8'h00;
            r_dout   <= 8'h00;
            r_ack    <= 1'b0;
            r_smp    <= 7'h7F;
            r_th_d   <= 1'b1;
            r_th_int <= 1'b0;
        end else begin
            r_ack <= cpu.cpu_sel;
            r_smp <= port_out;
            // th_d follows smp every cycle, which also reloads it on CTRL writes,
            // so a direction flip on a low pin cannot look like an edge.
            r_th_d   <= r_smp[6];
            r_th_int <= r_th_d & ~r_smp[6] & r_ctrl[7] & ~r_ctrl[6];
            if (w_wr && cpu.cpu_addr == 3'd0) r_data <= cpu.cpu_din;
            if (w_wr && cpu.cpu_addr == 3'd1) r_ctrl <= cpu.cpu_din;
            if (w_rd) r_dout <= w_rd_mux;
        end
    end

    assign cpu.cpu_ack  = r_ack;
    assign cpu.cpu_dout = r_dout;
    assign th_int       = r_th_int;

`ifdef MD_PORT_SERIAL_EN
    localparam int CW = $clog2(CLK_HZ / 300 + 1);

    typedef enum logic [0:0] {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [7:0]    r_txdata;
    logic [7:0]    r_rxdata;
    logic [4:0]    r_cfg;
    logic          r_rx_err;
    logic          r_rx_rdy;
    logic          r_tx_full;
    logic          r_ser_int;

    tx_state_t     r_tx_state;
    tx_state_t     w_tx_next;
    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic          w_tx_load;
    logic          w_tx_tick;
    logic          w_tx_line;

    rx_state_t     r_rx_state;
    rx_state_t     w_rx_next;
    logic [7:0]    r_rx_sh;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic          r_rx_prev;
    logic          w_rx_tick;
    logic          w_rx_done;

    logic [CW-1:0] w_period;
    logic          w_tx_en;
    logic          w_rx_en;
    logic          w_rx_line;

    assign w_tx_en   = r_cfg[1];
    assign w_rx_en   = r_cfg[2];
    assign w_rx_line = r_smp[5];
    assign w_tx_tick = (r_tx_cnt == '0);
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_tx_line = (r_tx_state == TX_IDLE) ? 1'b1 : r_tx_sh[0];

    always_comb begin
        w_period = CW'(CLK_HZ / 4800);
        case (r_cfg[4:3])
            2'd0:    w_period = CW'(CLK_HZ / 4800);
            2'd1:    w_period = CW'(CLK_HZ / 2400);
            2'd2:    w_period = CW'(CLK_HZ / 1200);
            default: w_period = CW'(CLK_HZ / 300);
        endcase
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_load = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (w_tx_en && r_tx_full) begin
                w_tx_load = 1'b1;
                w_tx_next = TX_SEND;
            end
            TX_SEND: if (w_tx_tick && r_tx_bit == 4'd9) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !w_rx_line) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = w_rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
        if (!w_rx_en) w_rx_next = RX_IDLE;
    end

    assign w_rx_done = (r_rx_state == RX_STOP) && w_rx_tick && w_rx_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txdata   <= 8'hFF;
            r_rxdata   <= 8'h00;
            r_cfg      <= 5'd0;
            r_rx_err   <= 1'b0;
            r_rx_rdy   <= 1'b0;
            r_tx_full  <= 1'b0;
            r_ser_int  <= 1'b0;
            r_tx_state <= TX_IDLE;
            r_tx_sh    <= '1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            r_rx_state <= RX_IDLE;
            r_rx_sh    <= 8'h00;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_prev  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
            r_rx_prev  <= w_rx_line;

            if (w_wr && cpu.cpu_addr == 3'd4) r_cfg <= cpu.cpu_din[7:3];
            if (w_wr && cpu.cpu_addr == 3'd2) begin
                r_txdata  <= cpu.cpu_din;
                r_tx_full <= 1'b1;
            end else if (w_tx_load) begin
                r_tx_full <= 1'b0;
            end

            if (w_tx_load) begin
                r_tx_sh  <= {1'b1, r_txdata, 1'b0};
                r_tx_cnt <= w_period - 1'b1;
                r_tx_bit <= 4'd0;
            end else if (r_tx_state == TX_SEND) begin
                if (w_tx_tick) begin
                    r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                    r_tx_cnt <= w_period - 1'b1;
                    r_tx_bit <= r_tx_bit + 4'd1;
                end else begin
                    r_tx_cnt <= r_tx_cnt - 1'b1;
                end
            end

            // Idle preloads the half-bit delay so the start bit is re-checked mid-bit.
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= (w_period >> 1) - 1'b1;
                    r_rx_bit <= 3'd0;
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_sh  <= {w_rx_line, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        r_rx_cnt <= w_period - 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: r_rx_cnt <= w_rx_tick ? w_period - 1'b1 : r_rx_cnt - 1'b1;
            endcase

            // A stop sample landing on the RXDATA read cycle wins over the clear.
            if (w_rd && cpu.cpu_addr == 3'd3) begin
                r_rx_rdy <= 1'b0;
                r_rx_err <= 1'b0;
            end
            if (w_rx_done) begin
                r_rxdata <= r_rx_sh;
                r_rx_rdy <= 1'b1;
                if (!w_rx_line || r_rx_rdy) r_rx_err <= 1'b1;
            end
            r_ser_int <= w_rx_done & r_cfg[0];
        end
    end

    always_comb begin
        w_ser_rd = 8'hFF;
        case (cpu.cpu_addr)
            3'd2:    w_ser_rd = r_txdata;
            3'd3:    w_ser_rd = r_rxdata;
            3'd4:    w_ser_rd = {r_cfg, r_rx_err, r_rx_rdy, r_tx_full};
            default: w_ser_rd = 8'hFF;
        endcase
    end

    assign port_dir = {r_ctrl[6], w_rx_en ? 1'b0 : r_ctrl[5], w_tx_en ? 1'b1 : r_ctrl[4], r_ctrl[3:0]};
    assign port_in  = {r_data[6:5], w_tx_en ? w_tx_line : r_data[4], r_data[3:0]};
    assign ser_int  = r_ser_int;
`else
    logic w_unused;
    assign w_unused = (CLK_HZ == 0);
    assign w_ser_rd = 8'hFF;
    assign port_dir = r_ctrl[6:0];
    assign port_in  = r_data[6:0];
    assign ser_int  = 1'b0;
`endif

endmodule

// File: tb/tb_md_port_regs.sv
// Directed bench for md_port_regs: register access, pin drive/sample, TH interrupt, optional serial.
module tb_md_port_regs;

    localparam int TB_CLK_HZ = 48000;   // 10 clocks per bit at 4800 baud
    localparam int BIT_CYC   = TB_CLK_HZ / 4800;

    logic       clk;
    logic       reset;
    logic [6:0] tb_po;
    logic       loop_en;
    wire  [6:0] port_in;
    wire  [6:0] port_dir;
    wire  [6:0] port_out;
    wire        th_int;
    wire        ser_int;

    md_port_regs_if bus ();

    assign port_out = loop_en ? {tb_po[6], port_in[4], tb_po[4:0]} : tb_po;

    md_port_regs #(.CLK_HZ(TB_CLK_HZ), .DATA_RST(8'h7F)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu      (bus.slave),
        .port_in  (port_in),
        .port_dir (port_dir),
        .port_out (port_out),
        .th_int   (th_int),
        .ser_int  (ser_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];   // {is_read, expected read data}
    string      tag_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are checked on the falling edge.
    task automatic tick();
        logic       sel_q;
        logic [8:0] e;
        string      t;
        sel_q = bus.cpu_sel;
        @(negedge clk);
        chk("ack_timing", {31'd0, bus.cpu_ack}, {31'd0, sel_q});
        if (sel_q && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e[8]) chk(t, {24'd0, bus.cpu_dout}, {24'd0, e[7:0]});
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_din = d;
        exp_q.push_back({1'b0, 8'h00});
        tag_q.push_back("wr");
        tick();
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] e, input string tag);
        bus.cpu_sel = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        exp_q.push_back({1'b1, e});
        tag_q.push_back(tag);
        tick();
        bus.cpu_sel = 1'b0;
    endtask

    task automatic count_pulses(input int cycles, input bit use_ser, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (use_ser ? ser_int : th_int) cnt++;
        end
    endtask

    initial begin
        int         cnt;
        logic [7:0] tx_byte;
        logic       exp_bit;

        reset = 1'b1; tb_po = 7'h55; loop_en = 1'b0;
        bus.cpu_sel = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 3'd0; bus.cpu_din = 8'h00;
        repeat (3) tick();
        chk("rst_dout", {24'd0, bus.cpu_dout}, 32'h00);
        chk("rst_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rst_th_int", {31'd0, th_int}, 32'd0);
        chk("rst_ser_int", {31'd0, ser_int}, 32'd0);
        chk("rst_port_dir", {25'd0, port_dir}, 32'h00);
        chk("rst_port_in", {25'd0, port_in}, 32'h7F);
        reset = 1'b0;
        tick();

        rd(3'd0, 8'h55, "data_rd_input");
        tick();
        chk("dout_hold", {24'd0, bus.cpu_dout}, 32'h55);

        wr(3'd1, 8'h40);
        wr(3'd0, 8'h00);
        tb_po = 7'h3F;
        tick();
        chk("pin_out_low", {25'd0, port_in}, 32'h00);
        chk("dir_th_out", {25'd0, port_dir}, 32'h40);
        rd(3'd0, 8'h3F, "data_rd_mixed");
        rd(3'd1, 8'h40, "ctrl_rd");
        wr(3'd0, 8'h40);
        chk("pin_out_high", {25'd0, port_in}, 32'h40);

        wr(3'd1, 8'h80);
        tb_po[6] = 1'b1;
        repeat (3) tick();
        tb_po[6] = 1'b0;
        tick();
        chk("th_int_early", {31'd0, th_int}, 32'd0);
        tick();
        chk("th_int_pulse", {31'd0, th_int}, 32'd1);
        tick();
        chk("th_int_end", {31'd0, th_int}, 32'd0);

        wr(3'd1, 8'hC0);
        tb_po[6] = 1'b1;
        repeat (3) tick();
        tb_po[6] = 1'b0;
        count_pulses(6, 1'b0, cnt);
        chk("th_int_th_output", cnt, 0);

        wr(3'd1, 8'h40);
        repeat (3) tick();
        wr(3'd1, 8'h80);
        count_pulses(6, 1'b0, cnt);
        chk("th_int_dir_switch", cnt, 0);

        rd(3'd6, 8'hFF, "rsvd6_rd");
        wr(3'd6, 8'h00);
        rd(3'd6, 8'hFF, "rsvd6_after_wr");
        rd(3'd5, 8'hFF, "rsvd5_rd");
        rd(3'd7, 8'hFF, "rsvd7_rd");
        wr(3'd1, 8'h81);
        rd(3'd1, 8'h81, "ctrl_rd_after_wr");
        rd(3'd0, 8'h3E, "data_rd_b2b");

`ifdef MD_PORT_SERIAL_EN
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h00);
        wr(3'd4, 8'h10);
        chk("tx_dir_forced", {25'd0, port_dir}, 32'h10);
        chk("tx_line_idle", {25'd0, port_in}, 32'h10);
        tx_byte = 8'hA5;
        wr(3'd2, tx_byte);
        rd(3'd4, 8'h11, "sctrl_tx_full");
        repeat (BIT_CYC / 2) tick();
        for (int k = 0; k < 10; k++) begin
            exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_byte[k-1];
            chk($sformatf("tx_bit%0d", k), {31'd0, port_in[4]}, {31'd0, exp_bit});
            repeat (BIT_CYC) tick();
        end
        chk("tx_line_done", {31'd0, port_in[4]}, 32'd1);
        rd(3'd4, 8'h10, "sctrl_tx_empty");

        loop_en = 1'b1;
        wr(3'd4, 8'h38);
        wr(3'd2, 8'hA5);
        count_pulses(14 * BIT_CYC, 1'b1, cnt);
        chk("ser_int_first", cnt, 1);
        rd(3'd4, 8'h3A, "sctrl_rx_ready");
        wr(3'd2, 8'h3C);
        count_pulses(14 * BIT_CYC, 1'b1, cnt);
        chk("ser_int_second", cnt, 1);
        rd(3'd4, 8'h3E, "sctrl_overrun");
        rd(3'd3, 8'h3C, "rxdata_rd");
        rd(3'd4, 8'h38, "sctrl_cleared");
`else
        rd(3'd2, 8'hFF, "txdata_absent");
        rd(3'd3, 8'hFF, "rxdata_absent");
        rd(3'd4, 8'hFF, "sctrl_absent");
        wr(3'd4, 8'h38);
        rd(3'd4, 8'hFF, "sctrl_wr_ignored");
        wr(3'd1, 8'h00);
        chk("dir_not_forced", {25'd0, port_dir}, 32'h00);
        count_pulses(20, 1'b1, cnt);
        chk("ser_int_tied", cnt, 0);
`endif

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
